// File: rtl/opb_register_bank_simulink2ppc_if.sv
// ---------------------------------------------------------------------------
// opb_register_bank_simulink2ppc_if
// OPB slave-side signal bundle for the multi-channel Simulink-to-PPC register
// bank. Vectors keep the OPB big-endian numbering ([0:31], bit 31 = LSB).
//   master modport : drives OPB_* request signals, receives Sl_* responses
//   slave  modport : receives OPB_* request signals, drives Sl_* responses
// ---------------------------------------------------------------------------
interface opb_register_bank_simulink2ppc_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_bank_simulink2ppc.sv
// ---------------------------------------------------------------------------
// opb_register_bank_simulink2ppc
// Samples C_NUM_CH user words into LIVE registers on user_data_valid and
// exposes SHADOW copies on an OPB slave window. Shadows follow LIVE every
// cycle while CTRL.AUTO=1, otherwise they update only on a SNAP write, which
// freezes all channels together. STATUS carries a 16-bit snapshot counter.
// Ports:
//   OPB_Clk, OPB_Rst_n : clock, asynchronous active-low reset
//   opb                : OPB slave bundle (address/data/control in, Sl_* out)
//   user_data_in       : C_NUM_CH packed channels, channel i at [i*W +: W]
//   user_data_valid    : capture strobe for user_data_in
// Optional feature: define OPB_REG_BANK_CHG_FLAG_EN to build the sticky CHG
// register at word 2+C_NUM_CH (cleared by reading it).
// ---------------------------------------------------------------------------
module opb_register_bank_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_CH     = 4,
  parameter int          C_DATA_WIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                             OPB_Clk,
  input  logic                             OPB_Rst_n,
  opb_register_bank_simulink2ppc_if.slave  opb,
  input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] user_data_in,
  input  logic                             user_data_valid
);

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_ACK, ST_WAIT} state_t;

  state_t                                   state_q, state_d;
  logic                                     ack_q, ack_d;
  logic [31:0]                              dbus_q, dbus_d;
  logic [29:0]                              idx_q, idx_d;
  logic                                     rnw_q, rnw_d;
  logic                                     auto_q, auto_d;
  logic [15:0]                              snap_cnt_q, snap_cnt_d;
  logic [C_NUM_CH-1:0][C_DATA_WIDTH-1:0]    live_q, live_d;
  logic [C_NUM_CH-1:0][C_DATA_WIDTH-1:0]    shadow_q, shadow_d;

  logic [31:0] addr_s, wdata_s, offset_s, rdata_s, status_s;
  logic [3:0]  be_s;
  logic [29:0] idx_s;
  logic        in_win_s, commit_s, ctrl_wr_s, snap_s, ack_out_s;

  // Re-number the big-endian bus vectors so bit 0 is the LSB.
  assign addr_s   = opb.OPB_ABus;
  assign wdata_s  = opb.OPB_DBus;
  assign be_s     = opb.OPB_BE;
  // Unsigned wrap makes addresses below the base land outside the span.
  assign offset_s = addr_s - C_BASEADDR;
  assign in_win_s = (offset_s <= (C_HIGHADDR - C_BASEADDR));
  assign idx_s    = offset_s[31:2];
  assign status_s = {5'd0, 6'(C_DATA_WIDTH), 5'(C_NUM_CH), snap_cnt_q};

  assign ctrl_wr_s = commit_s & ~rnw_q & (idx_q == 30'd0) & be_s[0];
  assign snap_s    = ctrl_wr_s & wdata_s[0];

`ifdef OPB_REG_BANK_CHG_FLAG_EN
  localparam logic [29:0] CHG_IDX = 30'(C_NUM_CH + 2);
  logic [C_NUM_CH-1:0] chg_q, chg_d;
  logic                chg_clr_s;
  assign chg_clr_s = commit_s & rnw_q & (idx_q == CHG_IDX);

  // Sticky change flags; a set in the clearing cycle wins over the clear.
  always_comb begin
    for (int i = 0; i < C_NUM_CH; i++) begin
      chg_d[i] = (chg_clr_s ? 1'b0 : chg_q[i]) |
                 (~auto_q & (live_q[i] != shadow_q[i]));
    end
  end

  // Change flag register.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) chg_q <= '0;
    else            chg_q <= chg_d;
  end
`endif

  // Read-data multiplexer driven from the current address during DECODE.
  always_comb begin
    rdata_s = 32'd0;
    if (idx_s == 30'd0) begin
      rdata_s = {30'd0, auto_q, 1'b0};
    end else if (idx_s == 30'd1) begin
      rdata_s = status_s;
    end else begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        if (idx_s == 30'(i + 2)) rdata_s = 32'(shadow_q[i]);
        else                     rdata_s = rdata_s;
      end
`ifdef OPB_REG_BANK_CHG_FLAG_EN
      if (idx_s == CHG_IDX) rdata_s = 32'(chg_q);
      else                  rdata_s = rdata_s;
`endif
    end
  end

  // Bus FSM next state: one ack per select assertion, write commits in ACK.
  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    dbus_d   = 32'd0;
    idx_d    = idx_q;
    rnw_d    = rnw_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (opb.OPB_select && in_win_s) state_d = ST_DECODE;
        else                            state_d = ST_IDLE;
      end
      ST_DECODE: begin
        if (!opb.OPB_select) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          idx_d   = idx_s;
          rnw_d   = opb.OPB_RNW;
          dbus_d  = opb.OPB_RNW ? rdata_s : 32'd0;
        end
      end
      ST_ACK: begin
        if (!opb.OPB_select) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_WAIT;
          commit_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!opb.OPB_select) state_d = ST_IDLE;
        else                 state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Channel and control next state. SHADOW copies the pre-update LIVE value.
  always_comb begin
    live_d     = user_data_valid ? user_data_in : live_q;
    shadow_d   = (auto_q | snap_s) ? live_q : shadow_q;
    auto_d     = ctrl_wr_s ? wdata_s[1] : auto_q;
    snap_cnt_d = snap_s ? snap_cnt_q + 16'd1 : snap_cnt_q;
  end

  // State, bus and register-bank flops.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      dbus_q     <= 32'd0;
      idx_q      <= 30'd0;
      rnw_q      <= 1'b0;
      auto_q     <= 1'b1;
      snap_cnt_q <= 16'd0;
      live_q     <= '0;
      shadow_q   <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      dbus_q     <= dbus_d;
      idx_q      <= idx_d;
      rnw_q      <= rnw_d;
      auto_q     <= auto_d;
      snap_cnt_q <= snap_cnt_d;
      live_q     <= live_d;
      shadow_q   <= shadow_d;
    end
  end

  // A master dropping select during ACK gets no acknowledge.
  assign ack_out_s      = ack_q & opb.OPB_select;
  assign opb.Sl_xferAck = ack_out_s;
  assign opb.Sl_DBus    = ack_out_s ? dbus_q : 32'd0;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  localparam bit unused_cfg = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32) &&
                              (C_FAMILY != "none");
  logic unused_s;
  assign unused_s = ^{opb.OPB_seqAddr, offset_s[1:0], wdata_s[31:2], be_s[3:1],
                      unused_cfg};

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
module tb_opb_register_bank_simulink2ppc;
  localparam int          NCH  = 4;
  localparam int          W    = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] HIGH = 32'h0000_00FF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH*W-1:0] user_data_in = '0;
  logic user_data_valid = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  opb_register_bank_simulink2ppc_if bus();

  opb_register_bank_simulink2ppc #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_NUM_CH(NCH), .C_DATA_WIDTH(W), .C_FAMILY("virtex6")
  ) dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .opb(bus.slave),
    .user_data_in(user_data_in), .user_data_valid(user_data_valid)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_live [NCH];
  logic [W-1:0] m_shadow [NCH];
  logic [NCH-1:0] m_chg;
  bit   m_auto;
  int   m_cnt;
  int   age;            // edges seen with select held, saturating at 3
  logic [31:0] m_rd;
  int   cnt_bias = 0;   // offset applied when the DUT counter is forced

  function automatic logic [29:0] word_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o[31:2];
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return (a - BASE) <= (HIGH - BASE);
  endfunction

  function automatic logic [31:0] reg_val(input logic [29:0] w);
    if (w == 30'd0) return m_auto ? 32'd2 : 32'd0;
    if (w == 30'd1) return (32'(W) << 21) | (32'(NCH) << 16) | ((m_cnt + cnt_bias) & 32'hFFFF);
    if (w >= 30'd2 && w < 30'(NCH + 2)) return 32'(m_shadow[w - 30'd2]);
`ifdef OPB_REG_BANK_CHG_FLAG_EN
    if (w == 30'(NCH + 2)) return 32'(m_chg);
`endif
    return 32'd0;
  endfunction

  function automatic bit commit_now();
    return bus.OPB_select && (age == 2);
  endfunction

  function automatic bit ctrl_write();
    return commit_now() && !bus.OPB_RNW && word_of(bus.OPB_ABus) == 30'd0 && bus.OPB_BE[3];
  endfunction

  function automatic bit is_snap();
    return ctrl_write() && bus.OPB_DBus[31];
  endfunction

  // Model state advance on every clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= 0; m_rd <= 32'd0; m_auto <= 1'b1; m_cnt <= 0; m_chg <= '0;
      for (int i = 0; i < NCH; i++) begin m_live[i] <= '0; m_shadow[i] <= '0; end
    end else begin
      if (!bus.OPB_select) age <= 0;
      else if (age == 0) age <= in_win(bus.OPB_ABus) ? 1 : 0;
      else if (age < 3) age <= age + 1;
      if (bus.OPB_select && age == 1)
        m_rd <= bus.OPB_RNW ? reg_val(word_of(bus.OPB_ABus)) : 32'd0;
      if (is_snap()) m_cnt <= (m_cnt + 1) & 32'hFFFF;
      if (ctrl_write()) m_auto <= bus.OPB_DBus[30];
      for (int i = 0; i < NCH; i++) begin
        if (m_auto || is_snap()) m_shadow[i] <= m_live[i];
        if (user_data_valid) m_live[i] <= user_data_in[i*W +: W];
`ifdef OPB_REG_BANK_CHG_FLAG_EN
        m_chg[i] <= ((commit_now() && bus.OPB_RNW && word_of(bus.OPB_ABus) == 30'(NCH + 2)) ? 1'b0 : m_chg[i])
                    | (!m_auto && (m_live[i] != m_shadow[i]));
`endif
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle compare of bus outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("xferAck", 32'(bus.Sl_xferAck), (bus.OPB_select && age == 2) ? 32'd1 : 32'd0);
      check("Sl_DBus", bus.Sl_DBus, (bus.OPB_select && age == 2) ? m_rd : 32'd0);
      check("tied", {29'd0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus_xfer(input bit rnw, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input bit pulse, input logic [NCH*W-1:0] pdata,
                          output logic [31:0] rdata, output bit acked, output int lat);
    @(posedge clk); #1;
    bus.OPB_select = 1'b1; bus.OPB_RNW = rnw; bus.OPB_ABus = addr;
    bus.OPB_DBus = wdata; bus.OPB_BE = be;
    acked = 1'b0; rdata = 32'd0; lat = -1;
    for (int k = 0; k < 6 && !acked; k++) begin
      @(negedge clk);
      if (bus.Sl_xferAck) begin
        acked = 1'b1; rdata = bus.Sl_DBus; lat = k;
        if (pulse) begin user_data_in = pdata; user_data_valid = 1'b1; end
      end
    end
    @(posedge clk); #1;
    bus.OPB_select = 1'b0; bus.OPB_RNW = 1'b0; bus.OPB_DBus = 32'd0; user_data_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d; bit a; int l;
    bus_xfer(1'b1, addr, 32'd0, 4'hF, 1'b0, '0, d, a, l);
    check({name, "_ack"}, 32'(a), 32'd1);
    check(name, d, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] d; bit a; int l;
    bus_xfer(1'b0, addr, data, be, 1'b0, '0, d, a, l);
    check("wr_ack", 32'(a), 32'd1);
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] v);
    @(posedge clk); #1;
    user_data_in[ch*W +: W] = v; user_data_valid = 1'b1;
    @(posedge clk); #1;
    user_data_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] d; bit a; int l;
    logic [NCH*W-1:0] pd;
    bus.OPB_select = 1'b0; bus.OPB_RNW = 1'b0; bus.OPB_ABus = 32'd0;
    bus.OPB_DBus = 32'd0; bus.OPB_BE = 4'h0; bus.OPB_seqAddr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state; STATUS = W(16) in [26:21], NCH(4) in [20:16].
    for (int i = 0; i < NCH; i++) rd("ch_reset", 32'(8 + 4*i), 32'd0);
    rd("ctrl_reset", 32'h0, 32'h0000_0002);
    bus_xfer(1'b1, 32'h4, 32'd0, 4'hF, 1'b0, '0, d, a, l);
    check("status_reset", d, 32'h0204_0000);
    check("ack_latency", 32'(l), 32'd2);

    // AUTO mode follows valid, holds when valid is low.
    set_ch(2, 16'hBEEF);
    rd("auto_ch2", 32'h10, 32'h0000_BEEF);
    user_data_in[2*W +: W] = 16'h1234;
    repeat (3) @(posedge clk);
    rd("auto_hold", 32'h10, 32'h0000_BEEF);

    // Manual mode: shadows freeze until SNAP.
    wr(32'h0, 32'h0, 4'hF);
    set_ch(0, 16'h1111);
    set_ch(1, 16'h2222);
    rd("frozen_ch0", 32'h08, 32'h0);
    rd("frozen_ch2", 32'h10, 32'h0000_BEEF);
    wr(32'h0, 32'h1, 4'hF);
    rd("snap_ch0", 32'h08, 32'h0000_1111);
    rd("snap_ch1", 32'h0C, 32'h0000_2222);
    rd("snap_ch2", 32'h10, 32'h0000_1234);
    rd("snap_cnt1", 32'h4, 32'h0204_0001);

    // SNAP in the same cycle as valid: shadow takes the older LIVE value.
    set_ch(0, 16'h5555);
    pd = user_data_in; pd[0 +: W] = 16'hAAAA;
    bus_xfer(1'b0, 32'h0, 32'h1, 4'hF, 1'b1, pd, d, a, l);
    check("snapvalid_ack", 32'(a), 32'd1);
    rd("snapvalid_ch0", 32'h08, 32'h0000_5555);
    wr(32'h0, 32'h1, 4'hF);
    rd("resnap_ch0", 32'h08, 32'h0000_AAAA);
    rd("snap_cnt3", 32'h4, 32'h0204_0003);

    // Byte-enable gating, read-only and unmapped writes.
    wr(32'h0, 32'h3, 4'b1110);
    rd("be_ctrl", 32'h0, 32'h0);
    wr(32'h4, 32'hFFFF_FFFF, 4'hF);
    wr(32'h40, 32'hFFFF_FFFF, 4'hF);
    rd("be_status", 32'h4, 32'h0204_0003);
    rd("unmapped", 32'h40, 32'h0);
`ifndef OPB_REG_BANK_CHG_FLAG_EN
    rd("chg_off", 32'h18, 32'h0);
`endif

    // Counter wrap after forcing near the top.
    @(negedge clk);
    force dut.snap_cnt_q = 16'hFFFE;
    cnt_bias = 32'hFFFE - m_cnt;
    #1 release dut.snap_cnt_q;
    wr(32'h0, 32'h1, 4'hF);
    rd("cnt_ffff", 32'h4, 32'h0204_FFFF);
    wr(32'h0, 32'h1, 4'hF);
    rd("cnt_wrap", 32'h4, 32'h0204_0000);

    // Out-of-window address gets no response.
    bus_xfer(1'b1, HIGH + 32'd4, 32'd0, 4'hF, 1'b0, '0, d, a, l);
    check("oow_noack", 32'(a), 32'd0);

    // Reset during DECODE: no ack, registers back to reset values.
    @(posedge clk); #1;
    bus.OPB_select = 1'b1; bus.OPB_RNW = 1'b1; bus.OPB_ABus = 32'h4;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_noack", 32'(bus.Sl_xferAck), 32'd0);
    end
    bus.OPB_select = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    rd("ctrl_after_rst", 32'h0, 32'h0000_0002);
    rd("ch0_after_rst", 32'h08, 32'h0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
